// File: rtl/jtag_scan_sequencer.sv
// JTAG master: runs TAP reset/init, then turns whole-register IR/DR scan requests into TCK/TMS/TDI sequences.
// Optional feature macro JTAG_SEQ_TDO_CHECK_EN: resp_err flags a scan that sampled an undriven TDO.
module jtag_scan_sequencer #(
    parameter int TCK_DIV = 4,
    parameter int MAX_LEN = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_is_ir,
    input  logic [6:0]         req_len,
    input  logic [MAX_LEN-1:0] req_data,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [MAX_LEN-1:0] resp_data,
    output logic               resp_err,
    output logic               busy,
    output logic               jtag_TCK,
    output logic               jtag_TMS,
    output logic               jtag_TDI,
    output logic               jtag_TRSTn,
    input  logic               jtag_TDO_data,
    input  logic               jtag_TDO_driven
);
    localparam int              PH_W              = $clog2(2 * TCK_DIV);
    localparam logic [PH_W-1:0] PH_LAST           = PH_W'(2 * TCK_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE           = PH_W'(TCK_DIV - 1);
    localparam logic [7:0]      INIT_PERIODS      = 8'd14;
    localparam logic [7:0]      INIT_TRST_PERIODS = 8'd8;
    localparam logic [6:0]      LEN_MAX           = 7'(MAX_LEN);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCAN, ST_RESP} state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [7:0]         per_q, per_d;
    logic [6:0]         bit_q, bit_d;
    logic [6:0]         len_q, len_d;
    logic               shift_q, shift_d;
    logic               is_ir_q, is_ir_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] mask_q, mask_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic               err_q, err_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               trstn_q, trstn_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d;

    logic               tdo_bit;
    logic [7:0]         pre;
    logic [7:0]         total;

    // per_q is the index of the next period to start; a period starts when phase_q wraps from PH_LAST.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        per_d        = per_q;
        bit_d        = bit_q;
        len_d        = len_q;
        shift_d      = shift_q;
        is_ir_d      = is_ir_q;
        data_d       = data_q;
        mask_d       = mask_q;
        cap_d        = cap_q;
        err_d        = err_q;
        tck_d        = tck_q;
        tms_d        = tms_q;
        tdi_d        = tdi_q;
        trstn_d      = trstn_q;
        tdo_bit      = jtag_TDO_driven & jtag_TDO_data;
        pre          = is_ir_q ? 8'd4 : 8'd3;
        total        = (len_q == 7'd0) ? 8'd0 : pre + {1'b0, len_q} + 8'd2;

        case (state_q)
            ST_INIT: begin
                if (phase_q == PH_LAST) begin
                    if (per_q == INIT_PERIODS) begin
                        state_d = ST_IDLE;
                        tck_d   = 1'b0;
                        tms_d   = 1'b0;
                    end else begin
                        phase_d = '0;
                        tck_d   = 1'b0;
                        tms_d   = (per_q != INIT_PERIODS - 8'd1);
                        trstn_d = (per_q >= INIT_TRST_PERIODS);
                        per_d   = per_q + 8'd1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PH_RISE) tck_d = 1'b1;
                end
            end
            ST_IDLE: begin
                tck_d = 1'b0;
                tms_d = 1'b0;
                tdi_d = 1'b0;
                if (req_valid && req_ready_q) begin
                    state_d = ST_SCAN;
                    is_ir_d = req_is_ir;
                    len_d   = (req_len > LEN_MAX) ? LEN_MAX : req_len;
                    data_d  = req_data;
                    mask_d  = MAX_LEN'(1);
                    cap_d   = '0;
                    err_d   = 1'b0;
                    per_d   = '0;
                    bit_d   = '0;
                    shift_d = 1'b0;
                    phase_d = PH_LAST;
                end
            end
            ST_SCAN: begin
                if (phase_q == PH_LAST) begin
                    if (per_q == total) begin
                        state_d = ST_RESP;
                        tck_d   = 1'b0;
                        tms_d   = 1'b0;
                        tdi_d   = 1'b0;
                        shift_d = 1'b0;
                    end else begin
                        phase_d = '0;
                        tck_d   = 1'b0;
                        tdi_d   = 1'b0;
                        shift_d = 1'b0;
                        per_d   = per_q + 8'd1;
                        if (per_q < pre) begin
                            tms_d = (per_q == 8'd0) || (is_ir_q && per_q == 8'd1);
                        end else if (bit_q < len_q) begin
                            shift_d = 1'b1;
                            tms_d   = (bit_q == len_q - 7'd1);
                            tdi_d   = data_q[0];
                            data_d  = data_q >> 1;
                            bit_d   = bit_q + 7'd1;
                        end else begin
                            // Exit1 -> Update-xR on the first post period, then back to Run-Test/Idle
                            tms_d = (per_q == pre + {1'b0, len_q});
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PH_RISE) begin
                        tck_d = 1'b1;
                        if (shift_q) begin
                            if (tdo_bit) cap_d = cap_q | mask_q;
                            mask_d = mask_q << 1;
`ifdef JTAG_SEQ_TDO_CHECK_EN
                            err_d = err_q | ~jtag_TDO_driven;
`endif
                        end
                    end
                end
            end
            ST_RESP: begin
                tck_d = 1'b0;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        busy_d       = (state_d == ST_INIT) || (state_d == ST_SCAN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            phase_q      <= PH_LAST;
            per_q        <= '0;
            bit_q        <= '0;
            len_q        <= '0;
            shift_q      <= 1'b0;
            is_ir_q      <= 1'b0;
            data_q       <= '0;
            mask_q       <= '0;
            cap_q        <= '0;
            err_q        <= 1'b0;
            tck_q        <= 1'b0;
            tms_q        <= 1'b1;
            tdi_q        <= 1'b0;
            trstn_q      <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            per_q        <= per_d;
            bit_q        <= bit_d;
            len_q        <= len_d;
            shift_q      <= shift_d;
            is_ir_q      <= is_ir_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            cap_q        <= cap_d;
            err_q        <= err_d;
            tck_q        <= tck_d;
            tms_q        <= tms_d;
            tdi_q        <= tdi_d;
            trstn_q      <= trstn_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = cap_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;
    assign jtag_TCK   = tck_q;
    assign jtag_TMS   = tms_q;
    assign jtag_TDI   = tdi_q;
    assign jtag_TRSTn = trstn_q;

endmodule
